// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests,
// and feeds IF/ID through an output register backed by a one-entry skid buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

  // state | meaning
  // IDLE  | no request outstanding
  // BUSY  | request outstanding, response will be kept
  // DROP  | request outstanding, response will be discarded (post-redirect)
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_issue;
  logic        w_accept;

  logic [31:0] r_next_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_instr;
  logic        r_out_valid;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_instr;
  logic        r_skid_valid;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!redirect_i && !r_skid_valid) begin
          w_state_nxt = S_BUSY;
          w_issue     = 1'b1;
        end
      end
      S_BUSY: begin
        if (imem_ack_i) begin
          if (redirect_i) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_accept = 1'b1;
            // A stalled ack lands in skid, so no new request until it drains
            if (stall_i) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_issue = 1'b1;
            end
          end
        end else if (redirect_i) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_ack_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_next_pc  <= START_PC;
      r_req_addr <= START_PC;
    end else if (redirect_i) begin
      r_next_pc <= {redirect_pc_i[31:2], 2'b00};
    end else if (w_issue) begin
      r_req_addr <= r_next_pc;
      r_next_pc  <= r_next_pc + 32'd4;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_out_pc     <= 32'd0;
      r_out_instr  <= 32'd0;
      r_out_valid  <= 1'b0;
      r_skid_pc    <= 32'd0;
      r_skid_instr <= 32'd0;
      r_skid_valid <= 1'b0;
    end else if (redirect_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!stall_i) begin
      if (r_skid_valid) begin
        r_out_pc     <= r_skid_pc;
        r_out_instr  <= r_skid_instr;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_pc    <= r_req_addr;
        r_out_instr <= imem_rdata_i;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_pc    <= r_req_addr;
      r_skid_instr <= imem_rdata_i;
      r_skid_valid <= 1'b1;
    end
  end

  assign imem_req_o  = (r_state != S_IDLE);
  assign imem_addr_o = r_req_addr;
  assign pc_o        = r_out_pc;
  assign instr_o     = r_out_instr;
  assign valid_o     = r_out_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-table runs plus stall/redirect/reset sequences,
// with a queue of expected consumed PCs checked whenever IF/ID takes an instruction.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] rpc = 32'd0;
  logic        req, ack;
  logic [31:0] addr, rdata, pc, instr;
  logic        valid;

  logic        rst2 = 1'b1;
  logic        stall2 = 1'b0;
  logic        redirect2 = 1'b0;
  logic [31:0] rpc2 = 32'd0;
  logic        req2, ack2;
  logic [31:0] addr2, rdata2, pc2, instr2;
  logic        valid2;

  int          lat = 1;
  int          cnt = 0;
  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] sb[$];
  logic        p_req = 1'b0;
  logic        p_ack = 1'b0;
  logic [31:0] p_addr = 32'd0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(rpc), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_rdata_i(rdata),
    .pc_o(pc), .instr_o(instr), .valid_o(valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk_i(clk), .rst_i(rst2), .stall_i(stall2), .redirect_i(redirect2),
    .redirect_pc_i(rpc2), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ack_i(ack2), .imem_rdata_i(rdata2),
    .pc_o(pc2), .instr_o(instr2), .valid_o(valid2)
  );

  // Memory: ack in the lat-th cycle of a request, data = address
  assign ack    = req && (cnt == lat - 1);
  assign rdata  = addr;
  assign ack2   = req2;
  assign rdata2 = addr2;

  always @(posedge clk) begin
    if (!req || ack) cnt <= 0;
    else             cnt <= cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // IF/ID consumes at an edge where valid_o=1 and stall_i=0
  always @(negedge clk) begin
    if (rst) begin
      if (valid && !stall) begin
        if (sb.size() == 0) begin
          check("sb_extra", pc, 32'hDEAD_DEAD);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          check("sb_pc", pc, e);
          check("sb_instr", instr, e);
        end
      end
      if (p_req && !p_ack && req) check("addr_hold", addr, p_addr);
      p_req  = req;
      p_ack  = ack;
      p_addr = addr;
    end else begin
      p_req = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst();
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
  endtask

  task automatic start(input int l);
    rst = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    lat = l;
    sb.delete();
    tick();
    tick();
    check_rst();
    rst = 1'b1;
  endtask

  task automatic finish_vec();
    @(negedge clk);
    #1;
    check("sb_drain", sb.size(), 32'd0);
  endtask

  typedef struct {
    int lat;
    int edges;
    int exp_n;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{lat: 1, edges: 8,  exp_n: 7};
    vecs[1] = '{lat: 2, edges: 9,  exp_n: 4};
    vecs[2] = '{lat: 3, edges: 10, exp_n: 3};
    vecs[3] = '{lat: 4, edges: 9,  exp_n: 2};

    #1 rst = 1'b0;
    rst2 = 1'b0;
    #1 check_rst();

    for (int i = 0; i < 4; i++) begin
      start(vecs[i].lat);
      for (int k = 0; k < vecs[i].exp_n; k++) sb.push_back(32'(k * 4));
      tick();
      check("first_req", {31'd0, req}, 32'd1);
      check("first_addr", addr, 32'd0);
      repeat (vecs[i].edges - 1) tick();
      finish_vec();
    end

    // stall for 4 edges while the fetch of 12 is acked
    start(1);
    sb = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20};
    repeat (4) tick();
    stall = 1'b1;
    for (int e = 5; e <= 8; e++) begin
      tick();
      check("stall_req", {31'd0, req}, 32'd0);
      check("stall_pc", pc, 32'd8);
      check("stall_valid", {31'd0, valid}, 32'd1);
    end
    stall = 1'b0;
    tick();
    check("unstall_pc", pc, 32'd12);
    check("unstall_req", {31'd0, req}, 32'd0);
    tick();
    check("unstall_bubble", {31'd0, valid}, 32'd0);
    check("unstall_addr", addr, 32'd16);
    tick();
    check("unstall_pc2", pc, 32'd16);
    tick();
    finish_vec();

    // redirect during an outstanding 3-cycle fetch of 0x10
    start(3);
    sb = '{32'd0, 32'd4, 32'd8, 32'hC, 32'h100};
    repeat (13) tick();
    check("pre_redir_addr", addr, 32'h10);
    redirect = 1'b1;
    rpc = 32'h103;
    tick();
    redirect = 1'b0;
    check("drop_valid", {31'd0, valid}, 32'd0);
    check("drop_addr", addr, 32'h10);
    tick();
    check("drop_req", {31'd0, req}, 32'd1);
    check("drop_addr2", addr, 32'h10);
    tick();
    check("drop_done_req", {31'd0, req}, 32'd0);
    tick();
    check("redir_req", {31'd0, req}, 32'd1);
    check("redir_addr", addr, 32'h100);
    repeat (3) tick();
    check("redir_pc", pc, 32'h100);
    finish_vec();

    // redirect coincident with ack and stall: output and skid flushed
    start(1);
    sb = '{32'd0, 32'h40};
    repeat (3) tick();
    stall = 1'b1;
    redirect = 1'b1;
    rpc = 32'h40;
    tick();
    redirect = 1'b0;
    check("flush_valid", {31'd0, valid}, 32'd0);
    check("flush_req", {31'd0, req}, 32'd0);
    tick();
    check("flush_addr", addr, 32'h40);
    check("flush_req2", {31'd0, req}, 32'd1);
    stall = 1'b0;
    tick();
    check("flush_pc", pc, 32'h40);
    finish_vec();

    // reset asserted while busy with a valid output
    start(1);
    sb = '{32'd0};
    repeat (3) tick();
    check("pre_rst_pc", pc, 32'd4);
    rst = 1'b0;
    #1 check_rst();
    check("rst_sb", sb.size(), 32'd0);

    // PC wrap from 0xFFFF_FFF8
    tick();
    rst2 = 1'b1;
    tick();
    check("wrap_addr0", addr2, 32'hFFFF_FFF8);
    tick();
    check("wrap_pc0", pc2, 32'hFFFF_FFF8);
    check("wrap_addr1", addr2, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc1", pc2, 32'hFFFF_FFFC);
    check("wrap_addr2", addr2, 32'h0000_0000);
    tick();
    check("wrap_pc2", pc2, 32'h0000_0000);
    check("wrap_instr2", instr2, 32'h0000_0000);
    check("wrap_valid2", {31'd0, valid2}, 32'd1);
    rst2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
